// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Holds the PC and issues one request at a time to
//   instruction memory over a valid/ready handshake. Each fetched instruction
//   is handed to decode together with its PC. A two-entry buffer (out slot +
//   skid slot) absorbs decode stalls. Branch/jal redirects from execute flush
//   everything buffered and discard any response still in flight.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   redirect_valid     one-cycle pulse from execute (branch taken / jal)
//   redirect_target    new PC, bits [1:0] ignored
//   imem_req_valid     fetch request valid (registered)
//   imem_req_ready     instruction memory accepts the request this cycle
//   imem_addr          word-aligned fetch address (the PC register)
//   imem_rsp_valid     response valid, no backpressure
//   imem_rsp_data      fetched instruction
//   instr_valid        instr/instr_pc valid to decode (registered)
//   decode_ready       decode consumes instr this cycle
//   instr, instr_pc    instruction and its PC; NOP_INSTR / 0 when empty
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned                 ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = {ADDRESS_WIDTH{1'b0}},
    parameter logic [31:0]                 NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    output logic                     instr_valid,
    input  logic                     decode_ready,
    output logic [31:0]              instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // request pending (or waiting for buffer space)
        ST_WAIT = 2'd1,   // one request in flight, response wanted
        ST_DROP = 2'd2    // one request in flight, response to be discarded
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP  = ADDRESS_WIDTH'(3'd4);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_PC  = {ADDRESS_WIDTH{1'b0}};

    state_t                     state;
    logic [ADDRESS_WIDTH-1:0]   pc;
    logic [ADDRESS_WIDTH-1:0]   inflight_pc;
    logic                       skid_valid;
    logic [31:0]                skid_data;
    logic [ADDRESS_WIDTH-1:0]   skid_pc;

    state_t                     state_next;
    logic [ADDRESS_WIDTH-1:0]   pc_next;
    logic [ADDRESS_WIDTH-1:0]   inflight_pc_next;
    logic                       out_valid_next;
    logic [31:0]                out_data_next;
    logic [ADDRESS_WIDTH-1:0]   out_pc_next;
    logic                       skid_valid_next;
    logic [31:0]                skid_data_next;
    logic [ADDRESS_WIDTH-1:0]   skid_pc_next;
    logic                       req_valid_next;

    logic                       handshake;
    logic                       transfer;
    logic                       in_flight;
    logic                       unused_target_bits;

    // The low target bits are forced to zero; keep them visibly consumed.
    assign unused_target_bits = ^redirect_target[1:0];

    // The PC register is the fetch address.
    assign imem_addr = pc;

    // Handshake qualifiers for the current cycle.
    always_comb begin
        handshake = (state == ST_REQ) && imem_req_valid && imem_req_ready;
        transfer  = instr_valid && decode_ready;
        in_flight = (state == ST_WAIT) || (state == ST_DROP);
    end

    // Next-state, PC and slot logic; redirect overrides everything else.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        inflight_pc_next = inflight_pc;
        out_valid_next   = instr_valid;
        out_data_next    = instr;
        out_pc_next      = instr_pc;
        skid_valid_next  = skid_valid;
        skid_data_next   = skid_data;
        skid_pc_next     = skid_pc;

        if (redirect_valid) begin
            pc_next         = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
            out_valid_next  = 1'b0;
            out_data_next   = NOP_INSTR;
            out_pc_next     = ZERO_PC;
            skid_valid_next = 1'b0;
            // A response still owed (or just requested) must be thrown away;
            // a response arriving this very cycle is consumed and dropped here.
            if (handshake || (in_flight && !imem_rsp_valid)) begin
                state_next = ST_DROP;
            end else begin
                state_next = ST_REQ;
            end
        end else begin
            // Decode took the out slot: refill it from the skid slot if possible.
            if (transfer) begin
                if (skid_valid) begin
                    out_valid_next  = 1'b1;
                    out_data_next   = skid_data;
                    out_pc_next     = skid_pc;
                    skid_valid_next = 1'b0;
                end else begin
                    out_valid_next  = 1'b0;
                    out_data_next   = NOP_INSTR;
                    out_pc_next     = ZERO_PC;
                end
            end else begin
                out_valid_next = instr_valid;
            end

            case (state)
                ST_REQ: begin
                    if (handshake) begin
                        state_next       = ST_WAIT;
                        inflight_pc_next = pc;
                        pc_next          = pc + PC_STEP;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // Requests are only issued with the skid slot empty, so the
                    // skid slot is always free while waiting here.
                    if (imem_rsp_valid) begin
                        state_next = ST_REQ;
                        if (!instr_valid || transfer) begin
                            out_valid_next = 1'b1;
                            out_data_next  = imem_rsp_data;
                            out_pc_next    = inflight_pc;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_data_next  = imem_rsp_data;
                            skid_pc_next    = inflight_pc;
                        end
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) begin
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
                default: begin
                    state_next = ST_REQ;
                end
            endcase
        end

        // Request next cycle only if a response could always land somewhere.
        // The current decode_ready predicts whether the out slot will drain;
        // once raised, a request is held until it is accepted.
        req_valid_next = (state_next == ST_REQ) && !skid_valid_next &&
                         (!out_valid_next || decode_ready ||
                          (imem_req_valid && (state == ST_REQ) && !handshake));
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            inflight_pc    <= ZERO_PC;
            skid_valid     <= 1'b0;
            skid_data      <= NOP_INSTR;
            skid_pc        <= ZERO_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            instr_pc       <= ZERO_PC;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            inflight_pc    <= inflight_pc_next;
            skid_valid     <= skid_valid_next;
            skid_data      <= skid_data_next;
            skid_pc        <= skid_pc_next;
            imem_req_valid <= req_valid_next;
            instr_valid    <= out_valid_next;
            instr          <= out_data_next;
            instr_pc       <= out_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit with a latency-programmable instruction memory model,
//   randomized ready/stall/redirect traffic and a few directed scenarios.
//   The reference model tracks only the architectural stream: the next
//   address that must be requested and the next PC that must reach decode.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        decode_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .decode_ready    (decode_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    int checks   = 0;
    int failures = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder / stimulus ----------------
    bit          pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt  = 0;
    int          stall_cnt = 0;
    logic [31:0] hs_q[$];          // accepted request addresses
    logic [31:0] dl_q[$];          // delivered PCs
    logic [31:0] dd_q[$];          // delivered instructions

    // rvm: 0 none, 1 always, 2 when a request is pending, 3 when a response arrives
    task automatic cycle(input bit rdy, input bit dr, input int rvm, input logic [31:0] tgt,
                         input bit rs, input int lat, output bit fired);
        @(negedge clk);
        rst            = rs;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        case (rvm)
            1:       fired = 1'b1;
            2:       fired = (imem_req_valid === 1'b1);
            3:       fired = imem_rsp_valid;
            default: fired = 1'b0;
        endcase
        redirect_valid  = fired;
        redirect_target = tgt;
        decode_ready    = dr;
        if (stall_cnt > 0 && instr_valid === 1'b1) begin
            decode_ready = 1'b0;
            stall_cnt--;
        end
        imem_req_ready = rdy && !rs;
        if (imem_req_ready && imem_req_valid === 1'b1) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = lat - 1;
            hs_q.push_back(imem_addr);
        end
    endtask

    task automatic step(input bit rdy, input bit dr, input int lat);
        bit f;
        cycle(rdy, dr, 0, 32'h0, 1'b0, lat, f);
    endtask

    task automatic do_reset();
        bit f;
        cycle(1'b0, 1'b1, 0, 32'h0, 1'b1, 1, f);
        cycle(1'b0, 1'b1, 0, 32'h0, 1'b1, 1, f);
    endtask

    // Entry idx of the handshake log (hs=1) or delivery log (hs=0).
    task automatic chk_log(input string name, input bit hs, input int idx, input logic [31:0] exp);
        int sz;
        sz = hs ? hs_q.size() : dl_q.size();
        if (idx >= sz) begin
            checks++;
            failures++;
            $display("FAIL %s: got no entry (log size %0d) expected %h", name, sz, exp);
        end else begin
            chk(name, hs ? hs_q[idx] : dl_q[idx], exp);
        end
    endtask

    // ---------------- reference model / compare process ----------------
    logic [31:0] nfpc = 32'h0;     // next address that must be requested
    logic [31:0] ndpc = 32'h0;     // next PC that must reach decode
    bit          outst = 1'b0, seen_rst = 1'b0, reset_next = 1'b0;
    bit          p_stall = 1'b0, p_reqhold = 1'b0, p_fast = 1'b0, p_rv = 1'b0;
    logic [31:0] p_instr, p_ipc, p_addr, p_tgt;

    always @(negedge clk) begin
        bit hs;
        #2;
        if (seen_rst) begin
            if (reset_next) begin
                chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
                chk("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
                chk("reset_instr", instr, NOP);
                chk("reset_instr_pc", instr_pc, 32'h0);
            end
            if (instr_valid === 1'b0) chk("nop_when_empty", instr, NOP);
            if (p_stall) begin
                chk("stall_hold_valid", {31'd0, instr_valid}, 32'd1);
                chk("stall_hold_instr", instr, p_instr);
                chk("stall_hold_pc", instr_pc, p_ipc);
            end
            if (p_reqhold) begin
                chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
                chk("req_hold_addr", imem_addr, p_addr);
            end
            if (p_rv) chk("flush_after_redirect", {31'd0, instr_valid}, 32'd0);
            if (p_fast) begin
                chk("redirect_latency_valid", {31'd0, imem_req_valid}, 32'd1);
                chk("redirect_latency_addr", imem_addr, p_tgt);
            end
        end
        reset_next = rst;
        if (rst) seen_rst = 1'b1;

        hs        = !rst && imem_req_valid && imem_req_ready;
        p_fast    = !rst && redirect_valid && (!outst || imem_rsp_valid) && !hs;
        p_stall   = !rst && !redirect_valid && instr_valid && !decode_ready;
        p_reqhold = !rst && !redirect_valid && imem_req_valid && !imem_req_ready;
        p_rv      = !rst && redirect_valid;
        p_tgt     = {redirect_target[31:2], 2'b00};
        p_instr   = instr;
        p_ipc     = instr_pc;
        p_addr    = imem_addr;

        if (rst) begin
            nfpc  = 32'h0;
            ndpc  = 32'h0;
            outst = 1'b0;
        end else begin
            if (hs) begin
                chk("one_outstanding", {31'd0, outst}, 32'd0);
                chk("fetch_addr", imem_addr, nfpc);
                nfpc = nfpc + 32'd4;
            end
            if (imem_rsp_valid) outst = 1'b0;
            if (hs) outst = 1'b1;
            if (instr_valid && decode_ready && !redirect_valid) begin
                chk("deliver_pc", instr_pc, ndpc);
                chk("deliver_instr", instr, mem_word(ndpc));
                dl_q.push_back(instr_pc);
                dd_q.push_back(instr);
                ndpc = ndpc + 32'd4;
            end
            if (redirect_valid) begin
                nfpc = p_tgt;
                ndpc = p_tgt;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int  hi, di, n;
        bit  f, t2_done;
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        decode_ready = 1'b1;

        // 1: in-order fetch with 1-cycle memory
        do_reset();
        hi = hs_q.size(); di = dl_q.size();
        step(1'b1, 1'b1, 1);
        chk("t1_no_instr_yet", {31'd0, instr_valid}, 32'd0);
        repeat (12) step(1'b1, 1'b1, 1);
        chk_log("t1_addr0", 1'b1, hi,     32'h0);
        chk_log("t1_addr1", 1'b1, hi + 1, 32'h4);
        chk_log("t1_addr2", 1'b1, hi + 2, 32'h8);
        chk_log("t1_pc0",   1'b0, di,     32'h0);
        chk_log("t1_pc2",   1'b0, di + 2, 32'h8);
        if (dd_q.size() > di) chk("t1_instr0", dd_q[di], 32'h0F0F_F0F0);

        // 2: five-cycle decode stall after the first instruction
        do_reset();
        di = dl_q.size();
        stall_cnt = 5; t2_done = 1'b0;
        repeat (20) begin
            step(1'b1, 1'b1, 1);
            if (stall_cnt == 2 && !t2_done) begin
                t2_done = 1'b1;
                chk("t2_req_blocked", {31'd0, imem_req_valid}, 32'd0);
                chk("t2_out_pc", instr_pc, 32'h0);
                chk("t2_out_valid", {31'd0, instr_valid}, 32'd1);
            end
        end
        chk("t2_stall_seen", {31'd0, t2_done}, 32'd1);
        chk_log("t2_pc0", 1'b0, di,     32'h0);
        chk_log("t2_pc1", 1'b0, di + 1, 32'h4);
        chk_log("t2_pc2", 1'b0, di + 2, 32'h8);

        // 3: redirect to 0x100 while the fetch of 0x8 is in flight
        do_reset();
        n = 0;
        while (n < 40 && !(hs_q.size() > 0 && hs_q[hs_q.size() - 1] == 32'h8 && pend)) begin
            step(1'b1, 1'b1, 3);
            n++;
        end
        cycle(1'b1, 1'b1, 1, 32'h100, 1'b0, 1, f);
        hi = hs_q.size(); di = dl_q.size();
        step(1'b1, 1'b1, 1);
        chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
        repeat (20) step(1'b1, 1'b1, 1);
        chk_log("t3_addr", 1'b1, hi, 32'h100);
        chk_log("t3_pc",   1'b0, di, 32'h100);

        // 4a: redirect in the cycle a request is accepted
        n = 0; f = 1'b0;
        while (n < 20 && !f) begin
            cycle(1'b1, 1'b1, 2, 32'h203, 1'b0, 2, f);
            n++;
        end
        chk("t4a_fired", {31'd0, f}, 32'd1);
        hi = hs_q.size(); di = dl_q.size();
        step(1'b1, 1'b1, 1);
        chk("t4a_flushed", {31'd0, instr_valid}, 32'd0);
        repeat (20) step(1'b1, 1'b1, 1);
        chk_log("t4a_addr", 1'b1, hi, 32'h200);
        chk_log("t4a_pc",   1'b0, di, 32'h200);

        // 4b: redirect in the cycle a response arrives
        n = 0; f = 1'b0;
        while (n < 20 && !f) begin
            cycle(1'b1, 1'b1, 3, 32'h203, 1'b0, 2, f);
            n++;
        end
        chk("t4b_fired", {31'd0, f}, 32'd1);
        di = dl_q.size();
        step(1'b1, 1'b1, 1);
        chk("t4b_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t4b_req_addr", imem_addr, 32'h200);
        repeat (20) step(1'b1, 1'b1, 1);
        chk_log("t4b_pc", 1'b0, di, 32'h200);

        // 5: request held while imem is not ready, then PC wraparound
        repeat (6) step(1'b0, 1'b1, 1);
        chk("t5_req_waiting", {31'd0, imem_req_valid}, 32'd1);
        cycle(1'b0, 1'b1, 1, 32'hFFFF_FFFC, 1'b0, 1, f);
        hi = hs_q.size(); di = dl_q.size();
        repeat (16) step(1'b1, 1'b1, 1);
        chk_log("t5_addr_top",  1'b1, hi,     32'hFFFF_FFFC);
        chk_log("t5_addr_wrap", 1'b1, hi + 1, 32'h0);
        chk_log("t5_pc_top",    1'b0, di,     32'hFFFF_FFFC);
        chk_log("t5_pc_wrap",   1'b0, di + 1, 32'h0);

        // 6: reset while a request is in flight; its late response is ignored
        hi = hs_q.size(); n = 0;
        while (n < 20 && hs_q.size() == hi) begin
            step(1'b1, 1'b1, 3);
            n++;
        end
        step(1'b0, 1'b1, 1);
        cycle(1'b0, 1'b1, 0, 32'h0, 1'b1, 1, f);
        step(1'b1, 1'b1, 1);
        chk("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("t6_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_instr", instr, NOP);
        hi = hs_q.size(); di = dl_q.size();
        repeat (15) step(1'b1, 1'b1, 1);
        chk_log("t6_addr", 1'b1, hi, 32'h0);
        chk_log("t6_pc",   1'b0, di, 32'h0);
        if (dd_q.size() > di) chk("t6_instr0", dd_q[di], 32'h0F0F_F0F0);

        // Randomized traffic
        di = dl_q.size();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: tgt = $urandom_range(0, 255);
            endcase
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 31) == 0) ? 1 : 0, tgt, 1'b0,
                  $urandom_range(1, 3), f);
        end
        repeat (10) step(1'b1, 1'b1, 1);
        chk("random_progress", {31'd0, (dl_q.size() - di) >= 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
